pwm_ramp_gen: RTL

- Upstream stage of the PWM-ramp ADC. Generates a PWM whose duty cycle ramps up by one step per PWM period.
- Exports the current duty count to the edge-capture controller.
- Restarts the ramp when that controller pulses its clear output on a comparator (LVDS) trip.
- Flags an overflow when a full ramp completes without any trip.

---
 rtl/pwm_ramp_pkg.sv | 21 ++
 rtl/pwm_ramp_presc.sv | 41 ++++
 rtl/pwm_ramp_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pwm_ramp_pkg.sv
// Shared types and helpers for the PWM ramp generator.
// Contents: FSM state enum, default widths, carry/wrap helper.
// Optional feature macro used by the slice: PWM_RAMP_STEP_EN.
package pwm_ramp_pkg;

  localparam int unsigned DEF_NBITS   = 8;
  localparam int unsigned DEF_PRESC_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

  // True when base + inc no longer fits in nbits (valid for nbits < 32).
  function automatic logic carry_out(input int unsigned base,
                                     input int unsigned inc,
                                     input int unsigned nbits);
    return ((base + inc) >> nbits) != 0;
  endfunction

endpackage

// File: rtl/pwm_ramp_presc.sv
// Prescaler for the PWM ramp generator: emits one tick every div+1 clocks
// while run is high.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   run           : count enable; counter held at 0 when low
//   sync_clr      : synchronous restart of the count
//   div           : terminal count (tick when count == div)
//   tick          : combinational tick, high in the cycle count == div
module pwm_ramp_presc
  import pwm_ramp_pkg::*;
#(
  parameter int unsigned W = DEF_PRESC_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         run,
  input  logic         sync_clr,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] presc_q, presc_d;

  assign tick = run && (presc_q == div);

  always_comb begin
    presc_d = presc_q + W'(1);
    if (!run || sync_clr || tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/pwm_ramp_gen.sv
// PWM ramp generator: the duty count steps up once per PWM period
// (2^NBITS ticks) and restarts on clear_i from the edge-capture controller.
// Ports:
//   clk_i, rst_ni  : clock, async active-low reset
//   en_i           : ramp enable (level)
//   clear_i        : one-cycle ramp restart, honoured in RAMP only
//   presc_i        : tick divider, latched on IDLE->RAMP
//   step_i         : duty step, latched on IDLE->RAMP (PWM_RAMP_STEP_EN only)
//   pwm_o          : registered PWM output
//   pwm_dc_o       : current duty count
//   period_end_o   : one-cycle pulse, seen together with the updated duty count
//   ovf_o          : one-cycle pulse when the duty count wraps without a clear
//   busy_o         : high in RAMP
// Build option: define PWM_RAMP_STEP_EN to add step_i.
module pwm_ramp_gen
  import pwm_ramp_pkg::*;
#(
  parameter int unsigned NBITS   = DEF_NBITS,
  parameter int unsigned PRESC_W = DEF_PRESC_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               clear_i,
  input  logic [PRESC_W-1:0] presc_i,
`ifdef PWM_RAMP_STEP_EN
  input  logic [NBITS-1:0]   step_i,
`endif
  output logic               pwm_o,
  output logic [NBITS-1:0]   pwm_dc_o,
  output logic               period_end_o,
  output logic               ovf_o,
  output logic               busy_o
);

  localparam logic [NBITS-1:0] STEP_ONE = NBITS'(1);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_lat_q, presc_lat_d;
  logic [NBITS-1:0]   cnt_q, cnt_d;
  logic [NBITS-1:0]   dc_q, dc_d;
  logic               pwm_q, pwm_d;
  logic               period_end_q, period_end_d;
  logic               ovf_q, ovf_d;
  logic [NBITS-1:0]   step_eff;
  logic               run, sync_clr, tick;

`ifdef PWM_RAMP_STEP_EN
  logic [NBITS-1:0]   step_lat_q, step_lat_d;
  assign step_eff = (step_lat_q == '0) ? STEP_ONE : step_lat_q;
`else
  assign step_eff = STEP_ONE;
`endif

  assign run = (state_q == RAMP);
  // Leaving RAMP and clear_i both restart the ramp; neither may emit pulses.
  assign sync_clr = run && (!en_i || clear_i);

  pwm_ramp_presc #(
    .W(PRESC_W)
  ) u_presc (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .run      (run),
    .sync_clr (sync_clr),
    .div      (presc_lat_q),
    .tick     (tick)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i)  state_d = RAMP;
      RAMP:    if (!en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, duty update and registered outputs
  always_comb begin
    presc_lat_d  = presc_lat_q;
    cnt_d        = cnt_q;
    dc_d         = dc_q;
    period_end_d = 1'b0;
    ovf_d        = 1'b0;
`ifdef PWM_RAMP_STEP_EN
    step_lat_d   = step_lat_q;
`endif
    if (!run) begin
      cnt_d = '0;
      dc_d  = '0;
      if (en_i) begin
        presc_lat_d = presc_i;
`ifdef PWM_RAMP_STEP_EN
        step_lat_d  = step_i;
`endif
      end
    end else if (sync_clr) begin
      cnt_d = '0;
      dc_d  = '0;
    end else if (tick) begin
      cnt_d = cnt_q + STEP_ONE;
      if (carry_out(32'(cnt_q), 32'd1, NBITS)) begin
        period_end_d = 1'b1;
        dc_d         = dc_q + step_eff;
        ovf_d        = carry_out(32'(dc_q), 32'(step_eff), NBITS);
      end
    end
    // Compare on next-state values so pwm_o lines up with cnt_q.
    pwm_d = (state_d == RAMP) && (cnt_d < dc_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_lat_q  <= '0;
      cnt_q        <= '0;
      dc_q         <= '0;
      pwm_q        <= 1'b0;
      period_end_q <= 1'b0;
      ovf_q        <= 1'b0;
`ifdef PWM_RAMP_STEP_EN
      step_lat_q   <= '0;
`endif
    end else begin
      presc_lat_q  <= presc_lat_d;
      cnt_q        <= cnt_d;
      dc_q         <= dc_d;
      pwm_q        <= pwm_d;
      period_end_q <= period_end_d;
      ovf_q        <= ovf_d;
`ifdef PWM_RAMP_STEP_EN
      step_lat_q   <= step_lat_d;
`endif
    end
  end

  // Output logic
  assign pwm_o        = pwm_q;
  assign pwm_dc_o     = dc_q;
  assign period_end_o = period_end_q;
  assign ovf_o        = ovf_q;
  assign busy_o       = (state_q == RAMP);

endmodule
